// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: register word offsets and TCON bit positions.
package timer_pkg;

    localparam logic [2:0] TIMER_TH      = 3'd0;
    localparam logic [2:0] TIMER_TL      = 3'd1;
    localparam logic [2:0] TIMER_TCON    = 3'd2;
    localparam logic [2:0] TIMER_PRE     = 3'd3;
    localparam logic [2:0] TIMER_SYSTICK = 3'd4;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Enable-gated prescaler: counts 0..PRESCALE-1 and pulses tick on the wrap cycle.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        tick,
    output logic [15:0] count
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    // tick is the cycle whose edge wraps the count, so the timer acts on that same edge
    assign tick = en && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped interval timer with reload, free-running SYSTICK and a level IRQ
// held until software clears ST or IE.
module timer_irq
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWr,
    input  logic        MemRd,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] systick;
    logic        en;
    logic        ie;
    logic        st;
    logic        tick;
    logic [15:0] pre_count;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    assign unused_addr_bits = &{1'b0, Addr[1:0]};

    logic [2:0] word;
    logic       hit;
    assign word = Addr[4:2];
    assign hit  = (Addr[31:5] == BASE_ADDR[31:5]) && (word <= TIMER_SYSTICK);

    logic wr_th, wr_tl, wr_tcon, wr_systick;
    assign wr_th      = MemWr && hit && (word == TIMER_TH);
    assign wr_tl      = MemWr && hit && (word == TIMER_TL);
    assign wr_tcon    = MemWr && hit && (word == TIMER_TCON);
    assign wr_systick = MemWr && hit && (word == TIMER_SYSTICK);

    // A TL write swallows the tick, so it also suppresses the overflow event
    logic overflow;
    assign overflow = tick && !wr_tl && (tl == 32'hFFFF_FFFF);

    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick),
        .count (pre_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            en      <= 1'b0;
            ie      <= 1'b0;
            st      <= 1'b0;
            systick <= '0;
        end else begin
            if (wr_th) begin
                th <= WriteData;
            end

            if (wr_tl) begin
                tl <= WriteData;
            end else if (overflow) begin
                tl <= th;
            end else if (tick) begin
                tl <= tl + 32'd1;
            end

            // Hardware set is OR-ed over the software value so an overflow is never lost
            if (wr_tcon) begin
                en <= WriteData[TCON_EN];
                ie <= WriteData[TCON_IE];
                st <= WriteData[TCON_ST] | (overflow & ie);
            end else if (overflow && ie) begin
                st <= 1'b1;
            end

            if (wr_systick) begin
                systick <= WriteData;
            end else begin
                systick <= systick + 32'd1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word)
            TIMER_TH:      rd_mux = th;
            TIMER_TL:      rd_mux = tl;
            TIMER_TCON:    rd_mux = {29'd0, st, ie, en};
            TIMER_PRE:     rd_mux = {16'd0, pre_count};
            TIMER_SYSTICK: rd_mux = systick;
            default:       rd_mux = '0;
        endcase
    end

    assign ReadData = (MemRd && hit) ? rd_mux : 32'd0;
    assign IRQ      = ie & st;

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: a register/decode vector table plus hand-written
// sequences for reset, overflow, collisions, IE gating, prescaler and SYSTICK wrap.
module tb_timer_irq;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_PRE  = BASE + 32'h0C;
    localparam logic [31:0] A_SYS  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic        MemWr = 1'b0;
    logic        MemRd = 1'b0;
    logic [31:0] rd1, rd4;
    logic        irq1, irq4;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    timer_irq #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .Addr(Addr), .WriteData(WriteData),
        .MemWr(MemWr), .MemRd(MemRd), .ReadData(rd1), .IRQ(irq1)
    );

    timer_irq #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .Addr(Addr), .WriteData(WriteData),
        .MemWr(MemWr), .MemRd(MemRd), .ReadData(rd4), .IRQ(irq4)
    );

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        re;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Writes land on the next rising edge; returns 1ns after it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = a;
        WriteData = d;
        MemWr = 1'b1;
        @(posedge clk);
        #1;
        MemWr = 1'b0;
    endtask

    task automatic read_rd(input bit sel4, input logic [31:0] a, input logic re, output logic [31:0] v);
        Addr = a;
        MemRd = re;
        #1;
        v = sel4 ? rd4 : rd1;
        MemRd = 1'b0;
    endtask

    task automatic read_chk(input bit sel4, input logic [31:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        read_rd(sel4, a, 1'b1, v);
        check(name, v, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int pre_m;
        int tl_m;

        vecs[0]  = '{1'b1, A_TH,           32'hA5A5_5A5A, 1'b1, A_TH,           32'hA5A5_5A5A};
        vecs[1]  = '{1'b1, A_TL,           32'h0000_1234, 1'b1, A_TL,           32'h0000_1234};
        vecs[2]  = '{1'b1, A_TCON,         32'hFFFF_FFF8, 1'b1, A_TCON,         32'h0000_0000};
        vecs[3]  = '{1'b1, A_PRE,          32'h0000_0077, 1'b1, A_PRE,          32'h0000_0000};
        vecs[4]  = '{1'b1, BASE + 32'h14,  32'h0000_DEAD, 1'b1, BASE + 32'h14,  32'h0000_0000};
        vecs[5]  = '{1'b1, 32'h0000_0000,  32'h0000_0001, 1'b1, A_TH,           32'hA5A5_5A5A};
        vecs[6]  = '{1'b0, 32'h0000_0000,  32'h0000_0000, 1'b1, 32'h0000_0008,  32'h0000_0000};
        vecs[7]  = '{1'b1, BASE + 32'h1C,  32'h0000_FFFF, 1'b1, A_TL,           32'h0000_1234};
        vecs[8]  = '{1'b0, 32'h0000_0000,  32'h0000_0000, 1'b0, A_TH,           32'h0000_0000};
        vecs[9]  = '{1'b0, 32'h0000_0000,  32'h0000_0000, 1'b1, BASE + 32'h07,  32'h0000_1234};
        vecs[10] = '{1'b1, A_TCON,         32'h0000_0006, 1'b1, A_TCON,         32'h0000_0006};

        // Reset state, sampled while reset is held
        #12;
        check("reset_irq", {31'd0, irq1}, 32'd0);
        read_chk(0, A_TH, 32'd0, "reset_th");
        read_chk(0, A_SYS, 32'd0, "reset_systick");
        @(negedge clk);
        reset = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].waddr, vecs[i].wdata);
            read_rd(0, vecs[i].raddr, vecs[i].re, v);
            check($sformatf("vec%0d", i), v, vecs[i].exp);
        end
        check("sw_irq_set", {31'd0, irq1}, 32'd1);

        // Asynchronous reset mid-cycle with TL=0x1234 and IRQ=1
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_irq", {31'd0, irq1}, 32'd0);
        read_chk(0, A_TL, 32'd0, "async_reset_tl");
        read_chk(0, A_TH, 32'd0, "async_reset_th");
        read_chk(0, A_TCON, 32'd0, "async_reset_tcon");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        read_chk(0, A_TL, 32'd0, "tl_idle_after_reset");

        // Overflow with PRESCALE=1
        bus_write(A_TH, 32'hFFFF_FFF0);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        read_chk(0, A_TL, 32'hFFFF_FFFE, "tl_after_enable_edge");
        step();
        read_chk(0, A_TL, 32'hFFFF_FFFF, "tl_ffff");
        check("irq_before_ovf", {31'd0, irq1}, 32'd0);
        step();
        read_chk(0, A_TL, 32'hFFFF_FFF0, "tl_reload");
        check("irq_after_ovf", {31'd0, irq1}, 32'd1);
        bus_write(A_TCON, 32'h3);
        check("irq_cleared", {31'd0, irq1}, 32'd0);
        read_chk(0, A_TL, 32'hFFFF_FFF1, "tl_after_clear");

        // TCON clear on the exact overflow edge: set wins
        bus_write(A_TCON, 32'h0);
        bus_write(A_TH, 32'h0000_0100);
        bus_write(A_TL, 32'hFFFF_FFFD);
        bus_write(A_TCON, 32'h3);
        bus_write(A_TH, 32'h0000_0100);
        bus_write(A_TH, 32'h0000_0100);
        bus_write(A_TCON, 32'h3);
        check("irq_set_beats_clear", {31'd0, irq1}, 32'd1);
        read_chk(0, A_TL, 32'h0000_0100, "tl_reload_collision");

        // TL write on a tick edge, then TH write on an overflow edge
        bus_write(A_TL, 32'd5);
        read_chk(0, A_TL, 32'd5, "tl_write_beats_tick");
        bus_write(A_TL, 32'hFFFF_FFFF);
        read_chk(0, A_TL, 32'hFFFF_FFFF, "tl_write_all_ones");
        bus_write(A_TH, 32'h0000_0200);
        read_chk(0, A_TL, 32'h0000_0100, "tl_old_th_reload");
        read_chk(0, A_TH, 32'h0000_0200, "th_new_value");

        // IE gating
        bus_write(A_TCON, 32'h1);
        bus_write(A_TL, 32'hFFFF_FFFF);
        step();
        read_chk(0, A_TL, 32'h0000_0200, "tl_reload_ie0");
        read_chk(0, A_TCON, 32'h1, "st_stays_0");
        check("irq_ie0", {31'd0, irq1}, 32'd0);
        bus_write(A_TCON, 32'h6);
        read_chk(0, A_TCON, 32'h6, "tcon_sw_st");
        check("irq_sw_trigger", {31'd0, irq1}, 32'd1);

        // Prescaler with PRESCALE=4
        do_reset();
        bus_write(A_TCON, 32'h1);
        read_chk(1, A_PRE, 32'd0, "pre_at_enable");
        pre_m = 0;
        tl_m  = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (pre_m == 3) begin
                pre_m = 0;
                tl_m++;
            end else begin
                pre_m++;
            end
            read_chk(1, A_PRE, 32'(pre_m), $sformatf("pre_cyc%0d", i));
            read_chk(1, A_TL, 32'(tl_m), $sformatf("tl_cyc%0d", i));
        end
        bus_write(A_TCON, 32'h0);
        read_chk(1, A_PRE, 32'd3, "pre_at_disable");
        read_chk(1, A_TL, 32'd2, "tl_at_disable");
        repeat (5) step();
        read_chk(1, A_PRE, 32'd3, "pre_frozen");
        read_chk(1, A_TL, 32'd2, "tl_frozen");
        bus_write(A_TCON, 32'h1);
        read_chk(1, A_PRE, 32'd3, "pre_reenable");
        step();
        read_chk(1, A_PRE, 32'd0, "pre_continue");
        read_chk(1, A_TL, 32'd3, "tl_continue");

        // SYSTICK wrap and write priority
        bus_write(A_SYS, 32'hFFFF_FFFF);
        read_chk(0, A_SYS, 32'hFFFF_FFFF, "systick_written");
        step();
        read_chk(0, A_SYS, 32'd0, "systick_wrap");
        step();
        read_chk(0, A_SYS, 32'd1, "systick_inc");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/timer_irq.md
# timer_irq

Memory-mapped interval timer and interrupt source for the single-cycle MIPS core. It answers CPU load/store accesses in the peripheral address window and drives the core's `IRQ` input. The control unit consumes `IRQ` and gates it with the kernel bit. This block produces that request and holds it until software acknowledges it.

## Interface
- `BASE_ADDR`, 32'h4000_0000: base of the 5-word register window.
- `PRESCALE`, 1: TL increments once every `PRESCALE` enabled cycles. Legal range is 1..65535.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Addr` input 32: byte address from the ALU result. Bits [1:0] are ignored.
- `WriteData` input 32: store data.
- `MemWr` input 1: store strobe, sampled at the rising edge.
- `MemRd` input 1: load strobe.
- `ReadData` output 32: load data, combinational.
- `IRQ` output 1: level interrupt request to the core.

## Operation
- Register map, as word offsets from `BASE_ADDR`:
  - 0x00 TH: 32-bit reload value, R/W.
  - 0x04 TL: 32-bit counter, R/W.
  - 0x08 TCON: bit0 EN, bit1 IE, bit2 ST (status). Bits [31:3] read 0. R/W.
  - 0x0C PRE: current prescaler count, read-only; writes are ignored.
  - 0x10 SYSTICK: free-running 32-bit cycle counter, R/W.
- Hit decode: `Addr[31:5] == BASE_ADDR[31:5]` and `Addr[4:2]` in 0..4. Offsets 0x14..0x1C are misses.
- A miss or `MemRd` = 0 gives `ReadData` = 0.
- Writes on a miss are ignored.
- Prescaler runs only while EN = 1.
  - Counts 0..`PRESCALE`-1.
  - At `PRESCALE`-1 it wraps to 0 and issues a one-cycle tick.
  - With `PRESCALE` = 1 every enabled cycle is a tick.
  - When EN = 0 it holds its value and does not clear.
- On a tick:
  - If TL = 32'hFFFF_FFFF, TL loads TH (overflow event).
  - Otherwise TL increments by 1, modulo 2^32.
- Overflow event with IE = 1 sets ST. Overflow with IE = 0 leaves ST unchanged.
- `IRQ` = IE & ST, from registers only; no combinational path from bus inputs.
- SYSTICK increments every cycle, independent of EN, and wraps from 32'hFFFF_FFFF to 0.
- Collision priority, same cycle:
  - A bus write to TL beats a tick: the written value lands and the tick is discarded.
  - A bus write to SYSTICK beats the increment.
  - A bus write to TH during overflow: TL reloads from the old TH, and TH takes the new value.
  - A TCON write with bit2 = 0 during an overflow with IE = 1: ST ends at 1. A set beats a software clear, so no interrupt is lost.
  - A TCON write setting bit2 = 1 sets ST directly (software-triggered interrupt).
- Reset values, all asynchronous on `reset` = 0:
  - TH = 0, TL = 0, TCON = 0, PRE = 0, SYSTICK = 0.
  - `IRQ` = 0 immediately; `ReadData` = 0 while `MemRd` = 0.
  - Reset mid-count discards all state. Counting resumes only after software sets EN.

## Timing
- Reads are zero-latency combinational. They return pre-edge register values, consistent with a single-cycle load.
- Writes take effect at the `clk` edge where `MemWr` = 1.
- A write setting EN = 1 at edge N:
  - PRE first advances at edge N+1.
  - With `PRESCALE` = 1, TL first increments at edge N+1.
- Overflow at edge N: TL = TH, ST = 1, and `IRQ` = 1 after edge N.
- Interrupt period in enabled cycles is (2^32 − TH) × `PRESCALE`.
- `IRQ` stays high until software clears ST or IE. It deasserts after the clearing edge.
- Simultaneous `MemRd` and `MemWr` to the same register: `ReadData` shows the old value.

## Structure
- Shared package `timer_pkg` holds:
  - word-offset constants `TIMER_TH`, `TIMER_TL`, `TIMER_TCON`, `TIMER_PRE`, `TIMER_SYSTICK`;
  - TCON bit indices `TCON_EN`, `TCON_IE`, `TCON_ST`.
- One sub-module, `timer_prescaler`: the counter plus tick generator with inputs EN and `PRESCALE`, output tick and count.
- Decode, registers and read mux stay in `timer_irq`.

## Test plan
- Reset mid-count: reset with TL = 32'h1234 and `IRQ` = 1 → all registers read 0 and `IRQ` = 0 asynchronously. With EN = 0 after release, TL stays 0.
- Overflow, `PRESCALE` = 1: write TH = 32'hFFFF_FFF0, TL = 32'hFFFF_FFFE, TCON = 3'b011.
  - TL goes to FFFF_FFFF after one edge; `IRQ` rises after the second edge with TL = FFFF_FFF0.
  - Writing TCON = 3'b011 clears `IRQ` on the next edge.
- Prescaler, `PRESCALE` = 4, EN = 1: TL advances exactly once per 4 cycles. Clearing EN freezes PRE and TL, and re-enabling continues from the frozen PRE value.
- Collision: write TCON = 3'b011 on the exact overflow edge with IE = 1 → ST = 1 and `IRQ` stays high. Write TL = 5 on a tick edge → TL reads 5.
- IE gating: overflow with IE = 0 → ST stays 0. Then writing TCON = 3'b110 → `IRQ` = 1 after that edge.
- Decode: read at `BASE_ADDR`+0x14 and at 32'h0000_0008 → `ReadData` = 0. Write to PRE → value unchanged.
- SYSTICK: write 32'hFFFF_FFFF → it reads 0 one cycle later.
